uart_rx: RTL
============

# uart_rx

UART receiver that turns the asynchronous serial line into parallel bytes. It is the receive-side consumer of the `uart_tick_generator` oversample tick (`SAMPLE_RATE` ticks per bit). It synchronises the line, validates the start bit at mid-bit, samples data LSB-first, and checks the stop bit. Received bytes go to downstream logic through a one-entry valid/ready output register, with framing-error and overrun flags.

## Interface
Parameters:
- `DATA_BITS`, 8, data bits per frame; legal range 5..9.
- `SAMPLE_RATE`, 16, `tick_in` pulses per bit period; must be even and ≥4.

Ports:
- `clk_in`  input  1  system clock; all logic is on its rising edge.
- `rst_n_in`  input  1  reset; asynchronous, active-low.
- `tick_in`  input  1  one-cycle oversample strobe from `uart_tick_generator`.
- `rx_in`  input  1  serial line; asynchronous to `clk_in`; idles high.
- `data_out`  output  DATA_BITS  received byte; stable while `valid_out`=1.
- `valid_out`  output  1  `data_out` holds an unconsumed byte.
- `ready_in`  input  1  consumer accepts `data_out` when `valid_out` && `ready_in`.
- `frame_err_out`  output  1  one-cycle pulse: stop bit sampled low.
- `overrun_out`  output  1  one-cycle pulse: good frame dropped because the output register is full.
- `busy_out`  output  1  high whenever state ≠ IDLE.

## Operation
- Synchroniser: two flops on `rx_in`, both reset to 1. All decisions use the second flop output, `rx_s`.
- Counters only advance on cycles with `tick_in`=1. Non-tick cycles hold all state except the output handshake.
- `cnt` is wide enough for `SAMPLE_RATE`-1. `bit_idx` is wide enough for `DATA_BITS`-1.
- State machine:
  - IDLE: on a tick with `rx_s`=0, go to START with `cnt`=0.
  - START: on a tick, if `cnt`==`SAMPLE_RATE`/2-1, evaluate `rx_s`:
    - 0: go to DATA with `cnt`=0, `bit_idx`=0.
    - 1: glitch. Go to IDLE with no flag.
    - Otherwise increment `cnt`.
  - DATA: on a tick, if `cnt`==`SAMPLE_RATE`-1, right-shift `rx_s` into the MSB of `shreg` (LSB arrives first) and set `cnt`=0. If `bit_idx`==`DATA_BITS`-1, go to STOP; otherwise increment `bit_idx`. Otherwise increment `cnt`.
  - STOP: on a tick with `cnt`==`SAMPLE_RATE`-1, evaluate `rx_s`:
    - 1: deliver the frame and go to IDLE. Returning at mid-stop-bit allows back-to-back frames.
    - 0: pulse `frame_err_out`, discard the frame, go to BREAK.
  - BREAK: stay until a tick with `rx_s`=1, then go to IDLE. A held-low line therefore produces exactly one framing error.
- Delivery of a good frame:
  - If `valid_out`=0, or `ready_in`=1 in the same cycle: load `data_out`←`shreg`, set `valid_out`=1.
  - If `valid_out`=1 and `ready_in`=0: keep the old data, drop the new byte, pulse `overrun_out`.
- `valid_out` clears on a cycle with `valid_out` && `ready_in` and no simultaneous load.
- Reset, asserted at any time including mid-frame:
  - state=IDLE; `cnt`, `bit_idx`, `shreg`=0; synchroniser flops=1.
  - `data_out`=0, `valid_out`=0, `frame_err_out`=0, `overrun_out`=0, `busy_out`=0.
  - A partially received frame is lost with no flags.

## Timing
- Input latency: `rx_in` to `rx_s` is 2 `clk_in` cycles.
- Sample points, counted in ticks after the start-detect tick:
  - start-bit check at tick `SAMPLE_RATE`/2 (8 for the default);
  - data bit n sampled `SAMPLE_RATE`·(n+1) ticks after the start check;
  - stop bit sampled `SAMPLE_RATE`·(`DATA_BITS`+1) ticks after the start check.
- `valid_out`, `data_out` and `overrun_out` update on the clock edge of the stop-sample tick, visible the next cycle. `frame_err_out` follows the same rule.
- Flag pulses are exactly one `clk_in` cycle wide.
- `busy_out` is registered from state. It rises the cycle after the start-detect tick and falls the cycle after the stop-sample or break-exit tick.
- Delivery with an existing byte and `ready_in`=1 in the same cycle: the old byte is consumed, the new byte loads, and `valid_out` stays 1 with no gap.

## Test plan
Setup: drive `tick_in` directly, one pulse every 4 clk (64 clk per bit), with default parameters.

- **Reset:** hold `rst_n_in`=0 mid-frame (after 3 data bits) → all outputs 0 immediately. After release with `rx_in`=1 for 20 bit-times → no `valid_out`, `busy_out`=0.
- **Single byte:** send 0xA5 (8N1) with `ready_in`=1 → `data_out`=0xA5, `valid_out` high for exactly 1 cycle, no flags, `busy_out` low afterwards.
- **Glitch rejection:** pulse `rx_in` low for 3 ticks → START aborts at tick 8. No `valid_out`, no `frame_err_out`, `busy_out` back to 0.
- **Framing error:** send 0x3C with stop bit=0, then hold `rx_in` low for 2 more bit-times, then high, then send 0x55 → one `frame_err_out` pulse and no `valid_out` for 0x3C. 0x55 is then delivered correctly.
- **Overrun:** with `ready_in`=0, send 0x11 then 0x22 → `valid_out`=1 with `data_out`=0x11 throughout, one `overrun_out` pulse at 0x22's stop sample. Raising `ready_in` for 1 cycle → `valid_out`=0 on the next cycle.
- **Back-to-back:** send 0x00, 0xFF, 0x80 with no idle gap between frames and `ready_in`=1 → three bytes delivered in order with values intact and no flags.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver.
// Synchronises the serial line, qualifies the start bit at mid-bit, shifts
// data in LSB-first, checks the stop bit and hands each good byte to a
// one-entry valid/ready output register. Framing errors and overruns are
// reported as single-cycle pulses.

`timescale 1ns/1ps

module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int SAMPLE_RATE = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 tick_in,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 frame_err_out,
    output logic                 overrun_out,
    output logic                 busy_out
);

    // Counter widths: cnt must hold SAMPLE_RATE-1, bit_idx must hold DATA_BITS-1.
    localparam int CNT_W = $clog2(SAMPLE_RATE);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SAMPLE_RATE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_RATE - 1);

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    localparam logic [DATA_BITS-1:0] DATA_ZERO = {DATA_BITS{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_e;

    // Line synchroniser
    logic rx_meta_q;
    logic rx_sync_q;
    logic rx_s;

    // Receive state machine
    state_e               state_q;
    state_e               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [IDX_W-1:0]     bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] shreg_d;
    logic                 deliver_s;
    logic                 ferr_s;

    // Output register and flags
    logic                 load_s;
    logic [DATA_BITS-1:0] data_q;
    logic [DATA_BITS-1:0] data_d;
    logic                 valid_q;
    logic                 valid_d;
    logic                 frame_err_q;
    logic                 frame_err_d;
    logic                 overrun_q;
    logic                 overrun_d;
    logic                 busy_q;
    logic                 busy_d;

    // Two-flop synchroniser; both stages reset to the idle (high) line level.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign rx_s = rx_sync_q;

    // Receive state, oversample counter, bit index and shift register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            bit_idx_q <= IDX_ZERO;
            shreg_q   <= DATA_ZERO;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
        end
    end

    // Next-state logic: everything advances only on oversample ticks.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        deliver_s = 1'b0;
        ferr_s    = 1'b0;

        if (tick_in) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d = ST_START;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d = CNT_ZERO;
                        if (!rx_s) begin
                            // Start bit still low at mid-bit: a real frame.
                            state_d   = ST_DATA;
                            bit_idx_d = IDX_ZERO;
                        end else begin
                            // Line went back high: treat as noise, no flag.
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        // LSB arrives first, so shift right and insert at MSB.
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        cnt_d   = CNT_ZERO;
                        if (bit_idx_q == IDX_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + IDX_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                ST_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = CNT_ZERO;
                        if (rx_s) begin
                            // Leaving at mid-stop-bit lets the next start edge be caught.
                            deliver_s = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            ferr_s  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                ST_BREAK: begin
                    // Wait out a held-low line so it reports only one framing error.
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BREAK;
                    end
                end

                default: begin
                    state_d   = ST_IDLE;
                    cnt_d     = CNT_ZERO;
                    bit_idx_d = IDX_ZERO;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output register next-state: load, consume, overrun and flag pulses.
    always_comb begin
        load_s      = deliver_s && (!valid_q || ready_in);
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = deliver_s && valid_q && !ready_in;
        frame_err_d = ferr_s;
        busy_d      = (state_d != ST_IDLE);

        if (load_s) begin
            // A same-cycle consume and load keeps valid high with no gap.
            data_d  = shreg_q;
            valid_d = 1'b1;
        end else if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_q      <= DATA_ZERO;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign data_out      = data_q;
    assign valid_out     = valid_q;
    assign frame_err_out = frame_err_q;
    assign overrun_out   = overrun_q;
    assign busy_out      = busy_q;

endmodule
